// File: rtl/ocm_arb_pkg.sv
// Shared types and defaults for the two-port on-chip memory arbiter.
package ocm_arb_pkg;

    localparam int OCM_ADDR_W = 10;
    localparam int OCM_DATA_W = 32;

    typedef logic [0:0] port_idx_t;

    localparam port_idx_t PORT_S0 = 1'b0;
    localparam port_idx_t PORT_S1 = 1'b1;

    // An outstanding read: its data returns from the RAM one cycle after issue.
    typedef struct packed {
        logic      valid;
        port_idx_t owner;
    } pend_rd_t;

    function automatic port_idx_t otherPort(input port_idx_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/ocm_rr_grant.sv
// Two-way grant selection with a round-robin pointer.
// Define OCM_ARB_FIXED_PRIO_EN to make s0 always win contention (no pointer).
module ocm_rr_grant
    import ocm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable_i,
    input  logic [1:0] req_i,
    output logic       gntValid_o,
    output port_idx_t  gntIdx_o
);

    port_idx_t contendWinner;

`ifdef OCM_ARB_FIXED_PRIO_EN
    logic unusedClkRst;

    assign unusedClkRst  = clk ^ reset_n;
    assign contendWinner = PORT_S0;
`else
    port_idx_t ptr_q;
    port_idx_t ptr_d;

    assign contendWinner = ptr_q;

    // The pointer only advances on an accepted transfer, so it holds through freeze.
    always_comb begin
        ptr_d = ptr_q;
        if (gntValid_o) begin
            ptr_d = otherPort(gntIdx_o);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= PORT_S0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        gntValid_o = 1'b0;
        gntIdx_o   = PORT_S0;
        if (enable_i && (req_i != 2'b00)) begin
            gntValid_o = 1'b1;
            if (req_i == 2'b11) begin
                gntIdx_o = contendWinner;
            end else if (req_i[1]) begin
                gntIdx_o = PORT_S1;
            end else begin
                gntIdx_o = PORT_S0;
            end
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two requesters sharing one single-port RAM with 1-cycle read latency.
// Round-robin by default; OCM_ARB_FIXED_PRIO_EN selects fixed s0 priority.
module onchip_mem_arbiter
    import ocm_arb_pkg::*;
#(
    parameter  int ADDR_W = OCM_ADDR_W,
    parameter  int DATA_W = OCM_DATA_W,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze,

    input  logic [ADDR_W-1:0] s0_address,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,

    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic [1:0]  req;
    logic        arbEnable;
    logic        gntValid;
    port_idx_t   gntIdx;
    logic        selRead;
    logic        selWrite;
    pend_rd_t    pendRd_q;
    pend_rd_t    pendRd_d;

    assign req       = {s1_read | s1_write, s0_read | s0_write};
    // Gating with reset_n keeps every waitrequest high while reset is held.
    assign arbEnable = reset_n & ~freeze;

    ocm_rr_grant uGrant (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable_i   (arbEnable),
        .req_i      (req),
        .gntValid_o (gntValid),
        .gntIdx_o   (gntIdx)
    );

    assign selRead  = (gntIdx == PORT_S1) ? s1_read  : s0_read;
    assign selWrite = (gntIdx == PORT_S1) ? s1_write : s0_write;

    always_comb begin
        ram_chipselect = gntValid;
        ram_write      = gntValid & selWrite;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        if (gntValid) begin
            ram_address    = (gntIdx == PORT_S1) ? s1_address    : s0_address;
            ram_byteenable = (gntIdx == PORT_S1) ? s1_byteenable : s0_byteenable;
            ram_writedata  = (gntIdx == PORT_S1) ? s1_writedata  : s0_writedata;
        end
    end

    assign ram_clken      = reset_n;
    assign s0_waitrequest = ~(gntValid && (gntIdx == PORT_S0));
    assign s1_waitrequest = ~(gntValid && (gntIdx == PORT_S1));

    // Read with write set counts as a write, so it never creates a pending read.
    always_comb begin
        pendRd_d.valid = gntValid & selRead & ~selWrite;
        pendRd_d.owner = gntIdx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pendRd_q <= '0;
        end else begin
            pendRd_q <= pendRd_d;
        end
    end

    assign s0_readdatavalid = pendRd_q.valid && (pendRd_q.owner == PORT_S0);
    assign s1_readdatavalid = pendRd_q.valid && (pendRd_q.owner == PORT_S1);
    assign s0_readdata      = s0_readdatavalid ? ram_readdata : '0;
    assign s1_readdata      = s1_readdatavalid ? ram_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter; expectations follow OCM_ARB_FIXED_PRIO_EN.
module tb_onchip_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        freeze;
    logic [9:0]  s0_address,    s1_address;
    logic [3:0]  s0_byteenable, s1_byteenable;
    logic        s0_read,  s1_read;
    logic        s0_write, s1_write;
    logic [31:0] s0_writedata,  s1_writedata;
    logic        s0_waitrequest,   s1_waitrequest;
    logic [31:0] s0_readdata,      s1_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_readdata;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        expQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem [0:1023];

`ifdef OCM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    onchip_mem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .freeze           (freeze),
        .s0_address       (s0_address),
        .s0_byteenable    (s0_byteenable),
        .s0_read          (s0_read),
        .s0_write         (s0_write),
        .s0_writedata     (s0_writedata),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s1_address       (s1_address),
        .s1_byteenable    (s1_byteenable),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_writedata     (s1_writedata),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_writedata    (ram_writedata),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_clken        (ram_clken),
        .ram_readdata     (ram_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with byte enables and one cycle of read latency.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        ram_readdata = 32'h0;
    end

    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                end
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idleAll();
        freeze        = 1'b0;
        s0_address    = '0; s0_byteenable = '0; s0_read = 1'b0; s0_write = 1'b0; s0_writedata = '0;
        s1_address    = '0; s1_byteenable = '0; s1_read = 1'b0; s1_write = 1'b0; s1_writedata = '0;
    endtask

    task automatic applyStimulus(input int port, input logic rd, input logic wr,
                                 input logic [9:0] addr, input logic [3:0] be, input logic [31:0] wd);
        if (port == 0) begin
            s0_read = rd; s0_write = wr; s0_address = addr; s0_byteenable = be; s0_writedata = wd;
        end else begin
            s1_read = rd; s1_write = wr; s1_address = addr; s1_byteenable = be; s1_writedata = wd;
        end
    endtask

    task automatic expectRead(input int port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_s0_wait"}, s0_waitrequest, 1);
        checkOutput({tag, "_s1_wait"}, s1_waitrequest, 1);
        checkOutput({tag, "_s0_rdv"}, s0_readdatavalid, 0);
        checkOutput({tag, "_s1_rdv"}, s1_readdatavalid, 0);
        checkOutput({tag, "_s0_rdata"}, s0_readdata, 0);
        checkOutput({tag, "_s1_rdata"}, s1_readdata, 0);
        checkOutput({tag, "_cs"}, ram_chipselect, 0);
        checkOutput({tag, "_ram_write"}, ram_write, 0);
        checkOutput({tag, "_clken"}, ram_clken, 0);
    endtask

    // Monitor: pops the scoreboard whenever a port presents read data.
    always @(negedge clk) begin
        exp_t e;
        int   p;
        checkOutput("rdv_exclusive", {31'b0, s0_readdatavalid & s1_readdatavalid}, 0);
        if (s0_readdatavalid || s1_readdatavalid) begin
            p = s1_readdatavalid ? 1 : 0;
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rdv_unexpected actual=port%0d required=none at %0t", p, $time);
            end else begin
                e = expQ.pop_front();
                checkOutput("rdv_owner", p, e.port);
                checkOutput("rdv_data", (p == 1) ? s1_readdata : s0_readdata, e.data);
                checkOutput("rdata_other_zero", (p == 1) ? s0_readdata : s1_readdata, 0);
            end
        end else begin
            checkOutput("rdata_idle_zero", s0_readdata | s1_readdata, 0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        idleAll();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Requests during reset are never granted.
        applyStimulus(0, 1, 0, 10'd5, 4'hF, 32'h0);
        applyStimulus(1, 0, 1, 10'd7, 4'hF, 32'h12345678);
        @(negedge clk);
        checkResetOutputs("rst");

        // First cycle after release: s0 writes 0xDEADBEEF to address 5.
        nextCycle();
        reset_n = 1'b1;
        idleAll();
        applyStimulus(0, 0, 1, 10'd5, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("wr5_s0_wait", s0_waitrequest, 0);
        checkOutput("wr5_s1_wait", s1_waitrequest, 1);
        checkOutput("wr5_cs", ram_chipselect, 1);
        checkOutput("wr5_ram_write", ram_write, 1);
        checkOutput("wr5_addr", ram_address, 5);
        checkOutput("wr5_wdata", ram_writedata, 32'hDEADBEEF);
        checkOutput("clken_run", ram_clken, 1);

        nextCycle();
        idleAll();
        applyStimulus(0, 1, 0, 10'd5, 4'hF, 32'h0);
        expectRead(0, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("rd5_s0_wait", s0_waitrequest, 0);
        checkOutput("rd5_ram_write", ram_write, 0);

        nextCycle();
        idleAll();
        @(negedge clk);
        checkOutput("idle_cs", ram_chipselect, 0);
        checkOutput("idle_addr", ram_address, 0);
        checkOutput("idle_s0_wait", s0_waitrequest, 1);

        // s1 partial write over a preset zero, then read back.
        nextCycle();
        applyStimulus(1, 0, 1, 10'd9, 4'h3, 32'h11223344);
        @(negedge clk);
        checkOutput("wr9_s1_wait", s1_waitrequest, 0);
        checkOutput("wr9_be", ram_byteenable, 4'h3);
        nextCycle();
        idleAll();
        applyStimulus(1, 1, 0, 10'd9, 4'hF, 32'h0);
        expectRead(1, 32'h00003344);
        @(negedge clk);
        checkOutput("rd9_s1_wait", s1_waitrequest, 0);

        // Read and write together behaves as a write with no read data.
        nextCycle();
        idleAll();
        applyStimulus(1, 1, 1, 10'd20, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("rdwr_ram_write", ram_write, 1);
        checkOutput("rdwr_s1_wait", s1_waitrequest, 0);

        // Both ports read continuously for six cycles.
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            idleAll();
            applyStimulus(0, 1, 0, 10'd5, 4'hF, 32'h0);
            applyStimulus(1, 1, 0, 10'd9, 4'hF, 32'h0);
            g = FIXED ? 0 : (i % 2);
            expectRead(g, (g == 1) ? 32'h00003344 : 32'hDEADBEEF);
            @(negedge clk);
            checkOutput($sformatf("both_s0_wait_%0d", i), s0_waitrequest, (g != 0) ? 1 : 0);
            checkOutput($sformatf("both_s1_wait_%0d", i), s1_waitrequest, (g != 1) ? 1 : 0);
            checkOutput($sformatf("both_addr_%0d", i), ram_address, (g == 1) ? 9 : 5);
        end

        nextCycle();
        idleAll();

        // s0 read, then freeze for three cycles with both ports requesting.
        nextCycle();
        applyStimulus(0, 1, 0, 10'd5, 4'hF, 32'h0);
        expectRead(0, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("prefrz_s0_wait", s0_waitrequest, 0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(0, 1, 0, 10'd5, 4'hF, 32'h0);
            applyStimulus(1, 1, 0, 10'd9, 4'hF, 32'h0);
            freeze = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("frz_cs_%0d", i), ram_chipselect, 0);
            checkOutput($sformatf("frz_s0_wait_%0d", i), s0_waitrequest, 1);
            checkOutput($sformatf("frz_s1_wait_%0d", i), s1_waitrequest, 1);
        end
        nextCycle();
        freeze = 1'b0;
        g = FIXED ? 0 : 1;
        expectRead(g, (g == 1) ? 32'h00003344 : 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("unfrz_cs", ram_chipselect, 1);
        checkOutput("unfrz_s0_wait", s0_waitrequest, (g != 0) ? 1 : 0);
        checkOutput("unfrz_s1_wait", s1_waitrequest, (g != 1) ? 1 : 0);

        nextCycle();
        idleAll();

        // Reset pulsed the cycle after a read is accepted drops its data.
        nextCycle();
        applyStimulus(0, 1, 0, 10'd5, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("prerst_s0_wait", s0_waitrequest, 0);
        nextCycle();
        reset_n = 1'b0;
        applyStimulus(1, 0, 1, 10'd12, 4'hF, 32'hAABBCCDD);
        @(negedge clk);
        checkResetOutputs("midrst");
        nextCycle();
        reset_n = 1'b1;
        idleAll();
        applyStimulus(1, 0, 1, 10'd12, 4'hF, 32'hAABBCCDD);
        @(negedge clk);
        checkOutput("postrst_s1_wait", s1_waitrequest, 0);
        checkOutput("postrst_cs", ram_chipselect, 1);
        checkOutput("postrst_ram_write", ram_write, 1);
        nextCycle();
        idleAll();
        applyStimulus(1, 1, 0, 10'd12, 4'hF, 32'h0);
        expectRead(1, 32'hAABBCCDD);
        @(negedge clk);
        checkOutput("rd12_s1_wait", s1_waitrequest, 0);

        nextCycle();
        idleAll();
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
